tag_array_sequencer: RTL and testbench

//  Owns the single RW port of the 16x23 cache tag SRAM (active-low csb0/web0).

---
 rtl/tag_ctrl_pkg.sv | 10 +
 rtl/tag_array_sequencer_if.sv | 25 ++
 rtl/rr_arb2.sv | 41 ++++
 rtl/tag_array_sequencer.sv | 102 ++++++++++
 tb/tb_tag_array_sequencer.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/tag_ctrl_pkg.sv
// Shared types and default geometry for the cache tag-array control path.
package tag_ctrl_pkg;

    localparam int TAG_DATA_WIDTH = 23;
    localparam int TAG_ADDR_WIDTH = 4;

    typedef enum logic {CLEAR, RUN} tag_ctrl_state_t;
    typedef enum logic {GNT_RD, GNT_WR} tag_gnt_t;

endpackage

// File: rtl/tag_array_sequencer_if.sv
// Lookup-read and fill-write request channels into the tag-array sequencer.
interface tag_array_sequencer_if #(
    parameter int DW = tag_ctrl_pkg::TAG_DATA_WIDTH,
    parameter int AW = tag_ctrl_pkg::TAG_ADDR_WIDTH
);
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_ready;
    logic          rd_rvalid;
    logic [DW-1:0] rd_rdata;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ready;

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data,
        input  rd_ready, rd_rvalid, rd_rdata, wr_ready
    );

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
        output rd_ready, rd_rvalid, rd_rdata, wr_ready
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; bit 0 is the read requester, bit 1 the writer.
module rr_arb2
    import tag_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    tag_gnt_t last_grant_reg;
    tag_gnt_t last_grant_next;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_gnt
            localparam tag_gnt_t SELF = (gi == 0) ? GNT_RD : GNT_WR;
            // A lone requester always wins; on contention the one not served last wins.
            assign gnt[gi] = en & req[gi] & (~req[1-gi] | (last_grant_reg != SELF));
        end
    endgenerate

    always_comb begin
        last_grant_next = last_grant_reg;
        if (gnt[0]) begin
            last_grant_next = GNT_RD;
        end else if (gnt[1]) begin
            last_grant_next = GNT_WR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_reg <= GNT_WR;
        end else begin
            last_grant_reg <= last_grant_next;
        end
    end

endmodule

// File: rtl/tag_array_sequencer.sv
// Owns the single RW port of the tag SRAM: clear sweep after reset/flush,
// then arbitrates lookup reads against fill writes one access per cycle.
module tag_array_sequencer
    import tag_ctrl_pkg::*;
#(
    parameter int                    DATA_WIDTH = TAG_DATA_WIDTH,
    parameter int                    ADDR_WIDTH = TAG_ADDR_WIDTH,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    tag_array_sequencer_if.slave  bus,
    output logic                  init_done,
    output logic                  csb0,
    output logic                  web0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0
);

    tag_ctrl_state_t       state_reg, state_next;
    logic [ADDR_WIDTH-1:0] cnt_reg, cnt_next;
    logic                  rvalid_reg;
    logic                  arb_en;
    logic [1:0]            gnt;

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req ({bus.wr_req, bus.rd_req}),
        .en  (arb_en),
        .gnt (gnt)
    );

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        arb_en       = 1'b0;
        csb0         = 1'b1;
        web0         = 1'b1;
        addr0        = cnt_reg;
        din0         = INIT_VALUE;
        bus.rd_ready = 1'b0;
        bus.wr_ready = 1'b0;
        init_done    = 1'b0;
        if (!rst) begin
            case (state_reg)
                CLEAR: begin
                    csb0     = 1'b0;
                    web0     = 1'b0;
                    cnt_next = cnt_reg + 1'b1;
                    if (cnt_reg == {ADDR_WIDTH{1'b1}}) begin
                        state_next = RUN;
                        cnt_next   = '0;
                    end
                end
                RUN: begin
                    init_done = 1'b1;
                    if (flush) begin
                        state_next = CLEAR;
                        cnt_next   = '0;
                    end else begin
                        arb_en = 1'b1;
                        if (gnt[0]) begin
                            csb0         = 1'b0;
                            addr0        = bus.rd_addr;
                            bus.rd_ready = 1'b1;
                        end else if (gnt[1]) begin
                            csb0         = 1'b0;
                            web0         = 1'b0;
                            addr0        = bus.wr_addr;
                            din0         = bus.wr_data;
                            bus.wr_ready = 1'b1;
                        end
                    end
                end
                default: begin
                    state_next = CLEAR;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // The SRAM registers its read data, so validity simply trails acceptance by one cycle.
    assign bus.rd_rvalid = rvalid_reg & ~rst;
    assign bus.rd_rdata  = dout0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= CLEAR;
            cnt_reg    <= '0;
            rvalid_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            rvalid_reg <= bus.rd_ready;
        end
    end

endmodule

// File: tb/tb_tag_array_sequencer.sv
// Directed bench for tag_array_sequencer with a behavioural 16x23 RW SRAM attached.
module tb_tag_array_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        init_done, csb0, web0;
    logic [3:0]  addr0;
    logic [22:0] din0;
    logic [22:0] dout0 = 23'h0;

    int checks   = 0;
    int failures = 0;

    tag_array_sequencer_if bus ();

    tag_array_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .bus       (bus),
        .init_done (init_done),
        .csb0      (csb0),
        .web0      (web0),
        .addr0     (addr0),
        .din0      (din0),
        .dout0     (dout0)
    );

    always #5 clk = ~clk;

    // SRAM powers up with junk so the clear sweep is observable.
    logic [22:0] mem [16] = '{default: 23'h55AA3};
    always @(posedge clk) begin
        if (!csb0) begin
            if (!web0) mem[addr0] <= din0;
            else       dout0      <= mem[addr0];
        end
    end

    typedef struct {
        logic        rd_req;
        logic [3:0]  rd_addr;
        logic        wr_req;
        logic [3:0]  wr_addr;
        logic [22:0] wr_data;
        logic        exp_rd_ready;
        logic        exp_wr_ready;
        logic        exp_rvalid;
        logic [22:0] exp_rdata;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic rq, input logic [3:0] ra,
                         input logic wq, input logic [3:0] wa, input logic [22:0] wd,
                         input logic fl);
        @(negedge clk);
        rst         = r;
        bus.rd_req  = rq;
        bus.rd_addr = ra;
        bus.wr_req  = wq;
        bus.wr_addr = wa;
        bus.wr_data = wd;
        flush       = fl;
        #1;
        $display("t=%0t rst=%b fl=%b rd=%b/%h wr=%b/%h/%h | rrdy=%b wrdy=%b rv=%b rdata=%h init=%b csb=%b web=%b a=%h",
                 $time, r, fl, rq, ra, wq, wa, wd, bus.rd_ready, bus.wr_ready,
                 bus.rd_rvalid, bus.rd_rdata, init_done, csb0, web0, addr0);
    endtask

    function automatic logic [22:0] fill_data(input int i);
        return 23'h300000 + 23'(i) * 23'h01011;
    endfunction

    task automatic sweep_cycle(input int i);
        chk("sweep_csb0", {31'b0, csb0}, 32'd0);
        chk("sweep_web0", {31'b0, web0}, 32'd0);
        chk("sweep_addr", {28'b0, addr0}, i);
        chk("sweep_din", {9'b0, din0}, 32'd0);
        chk("sweep_init_done", {31'b0, init_done}, 32'd0);
        chk("sweep_rd_ready", {31'b0, bus.rd_ready}, 32'd0);
        chk("sweep_wr_ready", {31'b0, bus.wr_ready}, 32'd0);
    endtask

    initial begin
        bus.rd_req = 1'b0; bus.rd_addr = '0;
        bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;

        // Contention on R/W starting from last_grant=WR, then write/read turnaround.
        vecs[0]  = '{1'b1, 4'd0, 1'b1, 4'd9, 23'h12345, 1'b1, 1'b0, 1'b0, 23'h0};
        vecs[1]  = '{1'b1, 4'd0, 1'b1, 4'd9, 23'h12345, 1'b0, 1'b1, 1'b1, 23'h0};
        vecs[2]  = '{1'b1, 4'd0, 1'b1, 4'd9, 23'h12345, 1'b1, 1'b0, 1'b0, 23'h0};
        vecs[3]  = '{1'b1, 4'd0, 1'b1, 4'd9, 23'h12345, 1'b0, 1'b1, 1'b1, 23'h0};
        vecs[4]  = '{1'b0, 4'd0, 1'b0, 4'd0, 23'h0,     1'b0, 1'b0, 1'b0, 23'h0};
        vecs[5]  = '{1'b0, 4'd0, 1'b1, 4'd5, 23'h7ABCDE, 1'b0, 1'b1, 1'b0, 23'h0};
        vecs[6]  = '{1'b1, 4'd5, 1'b0, 4'd0, 23'h0,     1'b1, 1'b0, 1'b0, 23'h0};
        vecs[7]  = '{1'b1, 4'd9, 1'b0, 4'd0, 23'h0,     1'b1, 1'b0, 1'b1, 23'h7ABCDE};
        vecs[8]  = '{1'b0, 4'd0, 1'b0, 4'd0, 23'h0,     1'b0, 1'b0, 1'b1, 23'h12345};
        vecs[9]  = '{1'b1, 4'd2, 1'b1, 4'd2, 23'h00F0F, 1'b0, 1'b1, 1'b0, 23'h0};
        vecs[10] = '{1'b1, 4'd2, 1'b1, 4'd2, 23'h00F0F, 1'b1, 1'b0, 1'b0, 23'h0};
        vecs[11] = '{1'b0, 4'd0, 1'b0, 4'd0, 23'h0,     1'b0, 1'b0, 1'b1, 23'h00F0F};

        // Reset held with both requesters active.
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 4'd1, 1'b1, 4'd2, 23'h1, 1'b0);
        chk("rst_csb0", {31'b0, csb0}, 32'd1);
        chk("rst_web0", {31'b0, web0}, 32'd1);
        chk("rst_rd_ready", {31'b0, bus.rd_ready}, 32'd0);
        chk("rst_wr_ready", {31'b0, bus.wr_ready}, 32'd0);
        chk("rst_init_done", {31'b0, init_done}, 32'd0);
        chk("rst_rvalid", {31'b0, bus.rd_rvalid}, 32'd0);

        // Initial sweep: requests held but never granted.
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 4'd1, 1'b1, 4'd2, 23'h1, 1'b0);
            sweep_cycle(i);
        end
        drive(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 23'h0, 1'b0);
        chk("init_done_c16", {31'b0, init_done}, 32'd1);
        chk("idle_csb0", {31'b0, csb0}, 32'd1);

        for (int v = 0; v < 12; v++) begin
            drive(1'b0, vecs[v].rd_req, vecs[v].rd_addr, vecs[v].wr_req,
                  vecs[v].wr_addr, vecs[v].wr_data, 1'b0);
            chk($sformatf("vec%0d_rd_ready", v), {31'b0, bus.rd_ready}, {31'b0, vecs[v].exp_rd_ready});
            chk($sformatf("vec%0d_wr_ready", v), {31'b0, bus.wr_ready}, {31'b0, vecs[v].exp_wr_ready});
            chk($sformatf("vec%0d_rvalid", v), {31'b0, bus.rd_rvalid}, {31'b0, vecs[v].exp_rvalid});
            if (vecs[v].exp_rvalid)
                chk($sformatf("vec%0d_rdata", v), {9'b0, bus.rd_rdata}, {9'b0, vecs[v].exp_rdata});
        end

        // Fill every set, then stream reads back to back.
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b0, 4'd0, 1'b1, 4'(i), fill_data(i), 1'b0);
            chk("fill_wr_ready", {31'b0, bus.wr_ready}, 32'd1);
        end
        for (int i = 0; i <= 16; i++) begin
            drive(1'b0, (i < 16), 4'(i), 1'b0, 4'd0, 23'h0, 1'b0);
            chk("stream_rd_ready", {31'b0, bus.rd_ready}, (i < 16) ? 32'd1 : 32'd0);
            chk("stream_rvalid", {31'b0, bus.rd_rvalid}, (i > 0) ? 32'd1 : 32'd0);
            if (i > 0) chk("stream_rdata", {9'b0, bus.rd_rdata}, {9'b0, fill_data(i - 1)});
        end

        // Write set 3, read it, flush while a read is returning, then re-read after sweep.
        drive(1'b0, 1'b0, 4'd0, 1'b1, 4'd3, 23'h1, 1'b0);
        chk("f_wr_ready", {31'b0, bus.wr_ready}, 32'd1);
        drive(1'b0, 1'b1, 4'd3, 1'b0, 4'd0, 23'h0, 1'b0);
        chk("f_rd_ready", {31'b0, bus.rd_ready}, 32'd1);
        drive(1'b0, 1'b1, 4'd3, 1'b0, 4'd0, 23'h0, 1'b1);
        chk("flush_rd_ready", {31'b0, bus.rd_ready}, 32'd0);
        chk("flush_csb0", {31'b0, csb0}, 32'd1);
        chk("flush_rvalid", {31'b0, bus.rd_rvalid}, 32'd1);
        chk("flush_rdata", {9'b0, bus.rd_rdata}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 4'd3, 1'b0, 4'd0, 23'h0, (i == 4));
            sweep_cycle(i);
            if (i == 0) chk("flush_sweep_rvalid", {31'b0, bus.rd_rvalid}, 32'd0);
        end
        drive(1'b0, 1'b1, 4'd3, 1'b0, 4'd0, 23'h0, 1'b0);
        chk("post_flush_init_done", {31'b0, init_done}, 32'd1);
        chk("post_flush_rd_ready", {31'b0, bus.rd_ready}, 32'd1);
        drive(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 23'h0, 1'b0);
        chk("post_flush_rvalid", {31'b0, bus.rd_rvalid}, 32'd1);
        chk("post_flush_rdata", {9'b0, bus.rd_rdata}, 32'd0);

        // Reset in sweep cycle 7 restarts the sweep from set 0.
        drive(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 23'h0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 23'h0, 1'b0);
            chk("pre_rst_addr", {28'b0, addr0}, i);
        end
        drive(1'b1, 1'b1, 4'd7, 1'b0, 4'd0, 23'h0, 1'b0);
        chk("mid_rst_csb0", {31'b0, csb0}, 32'd1);
        chk("mid_rst_web0", {31'b0, web0}, 32'd1);
        chk("mid_rst_init_done", {31'b0, init_done}, 32'd0);
        chk("mid_rst_rd_ready", {31'b0, bus.rd_ready}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 4'd7, 1'b0, 4'd0, 23'h0, 1'b0);
            sweep_cycle(i);
        end
        drive(1'b0, 1'b1, 4'd7, 1'b0, 4'd0, 23'h0, 1'b0);
        chk("restart_init_done", {31'b0, init_done}, 32'd1);
        chk("restart_rd_ready", {31'b0, bus.rd_ready}, 32'd1);
        drive(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 23'h0, 1'b0);
        chk("restart_rvalid", {31'b0, bus.rd_rvalid}, 32'd1);
        chk("restart_rdata", {9'b0, bus.rd_rdata}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
